// File: rtl/iq_demod_seq_ctrl.sv
// iq_demod_seq_ctrl: sequences one ADC sample through the shared FIR, I phase then Q phase, and decimates pairs.
// Latency: ready_adc 1 cycle after valid_adc seen in IDLE, I start at +2, Q start 1 cycle after I done, DONE 1 cycle after Q done.
// Backpressure: one accept per valid assertion; new rising edges while a sequence runs are dropped and flagged as overrun.
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   en               sequencer enable (checked only when leaving IDLE)
//   valid_adc        ADC sample valid level; sample_in is the sample
//   ready_adc        one-cycle accept pulse back to the ADC
//   fir_start        one-cycle start to the shared FIR; fir_sel 0=I,1=Q; fir_data latched sample
//   fir_done         FIR phase complete pulse (only looked at in WAIT_I / WAIT_Q)
//   out_valid        one-cycle strobe every DECIM completed I/Q pairs
//   busy             high in every state except IDLE and HOLD
//   ovr_clr/overrun  clear input and sticky dropped-sample flag
//   timeout_err      sticky FIR watchdog flag
//
// Build option: define FIR_WATCHDOG_EN to add a per-phase watchdog of TIMEOUT cycles.
// Without it, timeout_err is tied low and the WAIT states wait for fir_done indefinitely.

module iq_demod_seq_ctrl #(
   parameter int DW      = 12,
   parameter int DECIM   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic          valid_adc,
   input  logic [DW-1:0] sample_in,
   output logic          ready_adc,
   output logic          fir_start,
   output logic          fir_sel,
   output logic [DW-1:0] fir_data,
   input  logic          fir_done,
   output logic          out_valid,
   output logic          busy,
   input  logic          ovr_clr,
   output logic          overrun,
   output logic          timeout_err
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ACCEPT = 3'd1;
   localparam logic [2:0] S_RUN_I  = 3'd2;
   localparam logic [2:0] S_WAIT_I = 3'd3;
   localparam logic [2:0] S_RUN_Q  = 3'd4;
   localparam logic [2:0] S_WAIT_Q = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;
   localparam logic [2:0] S_HOLD   = 3'd7;

   generate
      if (DECIM < 1 || TIMEOUT < 2) begin : g_param_check
         $error("iq_demod_seq_ctrl: DECIM must be >= 1 and TIMEOUT >= 2");
      end
   endgenerate

   logic [2:0]    state;
   logic [2:0]    state_nxt;
   logic [PW-1:0] pair_cnt;
   logic          pair_last;
   logic          valid_d;
   logic          valid_rise;
   logic [DW-1:0] sample_q;
   logic          wd_fire;
   logic          in_wait;

   assign pair_last  = (pair_cnt == PW'(DECIM - 1));
   assign valid_rise = valid_adc & ~valid_d;
   assign in_wait    = (state == S_WAIT_I) || (state == S_WAIT_Q);

`ifdef FIR_WATCHDOG_EN
   localparam int TW = $clog2(TIMEOUT);

   logic [TW-1:0] ph_cnt;
   logic [TW-1:0] ph_cnt_inc;
   logic          wd_err;

   assign ph_cnt_inc = ph_cnt + 1'b1;
   // Fires on the cycle the phase counter would reach TIMEOUT-1, so the flag and
   // the abort land together; a fir_done in that same cycle still wins.
   assign wd_fire    = in_wait && !fir_done && (ph_cnt_inc == TW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         ph_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         if ((state == S_RUN_I) || (state == S_RUN_Q)) begin
            ph_cnt <= '0;
         end else if (in_wait) begin
            ph_cnt <= ph_cnt_inc;
         end
         if (wd_fire) begin
            wd_err <= 1'b1;
         end
      end
   end

   assign timeout_err = wd_err;
`else
   assign wd_fire     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (en && valid_adc) state_nxt = S_ACCEPT;
         S_ACCEPT: state_nxt = S_RUN_I;
         S_RUN_I:  state_nxt = S_WAIT_I;
         S_WAIT_I: begin
            if (fir_done)     state_nxt = S_RUN_Q;
            else if (wd_fire) state_nxt = valid_adc ? S_HOLD : S_IDLE;
         end
         S_RUN_Q:  state_nxt = S_WAIT_Q;
         S_WAIT_Q: begin
            if (fir_done)     state_nxt = S_DONE;
            else if (wd_fire) state_nxt = valid_adc ? S_HOLD : S_IDLE;
         end
         // Park in HOLD while the ADC still holds valid so the same assertion
         // cannot be accepted twice.
         S_DONE:   state_nxt = valid_adc ? S_HOLD : S_IDLE;
         S_HOLD:   if (!valid_adc) state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         pair_cnt <= '0;
         valid_d  <= 1'b0;
         sample_q <= '0;
         overrun  <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_d <= valid_adc;
         if (state == S_ACCEPT) begin
            sample_q <= sample_in;
         end
         if (state == S_DONE) begin
            pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
         end
         // A fresh edge outside IDLE is a sample we will never take; set beats clear.
         if (valid_rise && (state != S_IDLE)) begin
            overrun <= 1'b1;
         end else if (ovr_clr) begin
            overrun <= 1'b0;
         end
      end
   end

   assign ready_adc = (state == S_ACCEPT);
   assign fir_start = (state == S_RUN_I) || (state == S_RUN_Q);
   assign fir_sel   = (state == S_RUN_Q) || (state == S_WAIT_Q);
   assign fir_data  = sample_q;
   assign out_valid = (state == S_DONE) && pair_last;
   assign busy      = (state != S_IDLE) && (state != S_HOLD);

endmodule
